// File: rtl/axi_sram_resp.sv
// AXI4 burst responder over an internal 64-bit memory; one read or write burst at a time.
// Optional `AXI_SRAM_RESP_ERR_EN: out-of-window beats return SLVERR instead of aliasing.
module axi_sram_resp #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  input  logic [1:0]  arburst,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  input  logic [1:0]  awburst,
  input  logic [7:0]  awlen,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  state_t      state;
  logic [63:0] mem [DEPTH];
  logic [31:0] addr;
  logic [31:0] addr_nxt;
  logic [7:0]  len;
  logic [7:0]  cnt;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic        wr_ok;
`ifdef AXI_SRAM_RESP_ERR_EN
  logic        werr;
`endif

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 3);
  endfunction

`ifdef AXI_SRAM_RESP_ERR_EN
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE) < (32'(DEPTH) << 3);
  endfunction
`endif

  // WRAP only wraps for the legal lengths 2/4/8/16 beats; anything else behaves as INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b,
                                             input logic [7:0] l, input logic [2:0] s);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = 32'd1 << s;
    mask = (({24'd0, l} + 32'd1) << s) - 32'd1;
    next_addr = a + incr;
    if (b == 2'd0)
      next_addr = a;
    else if (b == 2'd2 && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15))
      next_addr = (a & ~mask) | ((a + incr) & mask);
  endfunction

  function automatic logic [63:0] rd_word(input logic [31:0] a);
`ifdef AXI_SRAM_RESP_ERR_EN
    if (!in_range(a)) return '0;
`endif
    return mem[word_idx(a)];
  endfunction

  function automatic logic [1:0] rd_resp(input logic [31:0] a);
`ifdef AXI_SRAM_RESP_ERR_EN
    if (!in_range(a)) return 2'b10;
`endif
    return (a == a) ? 2'b00 : 2'b00;
  endfunction

  assign addr_nxt = next_addr(addr, burst, len, size);
  assign arready  = (state == IDLE);
  assign awready  = (state == IDLE) && !arvalid;
  assign wready   = (state == WDATA);

`ifdef AXI_SRAM_RESP_ERR_EN
  assign wr_ok = in_range(addr);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr   <= '0;
      len    <= '0;
      cnt    <= '0;
      size   <= '0;
      burst  <= '0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
`ifdef AXI_SRAM_RESP_ERR_EN
      werr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arvalid) begin
            addr   <= araddr;
            len    <= arlen;
            size   <= arsize;
            burst  <= arburst;
            cnt    <= '0;
            rvalid <= 1'b1;
            rlast  <= (arlen == 8'd0);
            rdata  <= rd_word(araddr);
            rresp  <= rd_resp(araddr);
            state  <= RDATA;
          end else if (awvalid) begin
            addr   <= awaddr;
            len    <= awlen;
            size   <= 3'd3;
            burst  <= awburst;
`ifdef AXI_SRAM_RESP_ERR_EN
            werr   <= 1'b0;
`endif
            state  <= WDATA;
          end
        end
        RDATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              addr  <= addr_nxt;
              cnt   <= cnt + 8'd1;
              rlast <= ((cnt + 8'd1) == len);
              rdata <= rd_word(addr_nxt);
              rresp <= rd_resp(addr_nxt);
            end
          end
        end
        WDATA: begin
          if (wvalid) begin
            addr <= addr_nxt;
`ifdef AXI_SRAM_RESP_ERR_EN
            if (!wr_ok) werr <= 1'b1;
`endif
            if (wlast) begin
              bvalid <= 1'b1;
`ifdef AXI_SRAM_RESP_ERR_EN
              bresp  <= (werr || !wr_ok) ? 2'b10 : 2'b00;
`else
              bresp  <= 2'b00;
`endif
              state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset so it maps onto plain RAM; writes commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == WDATA && wvalid && wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[word_idx(addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_resp.sv
// Directed plus randomized bench for axi_sram_resp against a flat memory reference model.
module tb_axi_sram_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_resp #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast),
    .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  string       cur = "init";
  logic [63:0] model [DEPTH];
  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];
  logic [63:0] got [16];

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s[%0d] got=%h want=%h", cur, tag, idx, obs, exp);
    end
  endtask

  // Byte address of beat i, derived directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [1:0] b,
                                             input logic [7:0] len, input logic [2:0] sz, input int i);
    logic [31:0] bs, ws, wb;
    bs = 32'd1 << sz;
    if (b == 2'd0) return s;
    if (b == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      ws = (32'(len) + 32'd1) * bs;
      wb = s - (s % ws);
      return wb + (((s - wb) + 32'(i) * bs) % ws);
    end
    return s + 32'(i) * bs;
  endfunction

  function automatic int midx(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) >> 3) % DEPTH;
    return int'(w);
  endfunction

  function automatic logic oor(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off >= 32'(8 * DEPTH);
  endfunction

  function automatic logic [63:0] exp_data(input logic [31:0] a);
`ifdef AXI_SRAM_RESP_ERR_EN
    if (oor(a)) return 64'd0;
`endif
    return model[midx(a)];
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
`ifdef AXI_SRAM_RESP_ERR_EN
    if (oor(a)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    w = model[midx(a)];
    for (int k = 0; k < 8; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
    model[midx(a)] = w;
  endtask

  // Tasks start and end on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [1:0] b, input logic [7:0] len, output int aw_wait);
    awaddr = a; awburst = b; awlen = len; awvalid = 1'b1;
    aw_wait = 0;
    while (!awready && aw_wait < 100) begin @(negedge clk); aw_wait++; end
    chk("awready", 0, awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready", 0, wready, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len)); wvalid = 1'b1;
      model_write(beat_addr(a, b, len, 3'd3, i), wbuf[i], sbuf[i]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_rise", 0, bvalid, 1'b1);
    chk("bresp", 0, bresp, 2'b00);
    @(negedge clk);
    chk("bvalid_hold", 0, bvalid, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_fall", 0, bvalid, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] b, input logic [7:0] len, input logic [2:0] sz,
                    input int stall_beat, input int stall_n, input bit rnd, output int ar_wait);
    logic [63:0] ed;
    logic [1:0]  er;
    int          ns;
    araddr = a; arburst = b; arlen = len; arsize = sz; arvalid = 1'b1;
    ar_wait = 0;
    while (!arready && ar_wait < 100) begin @(negedge clk); ar_wait++; end
    chk("arready", 0, arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_lat", 0, rvalid, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      ed = exp_data(beat_addr(a, b, len, sz, i));
      er = exp_resp(beat_addr(a, b, len, sz, i));
      ns = rnd ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall_n : 0);
      rready = 1'b0;
      for (int s = 0; s < ns; s++) begin
        chk("stall_data", i, rdata, ed);
        chk("stall_last", i, rlast, (i == int'(len)));
        @(negedge clk);
      end
      rready = 1'b1;
      chk("rvalid", i, rvalid, 1'b1);
      chk("rdata", i, rdata, ed);
      chk("rresp", i, rresp, er);
      chk("rlast", i, rlast, (i == int'(len)));
      got[i] = rdata;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("rvalid_end", 0, rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] lens [6];
    lens = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15, 8'd5};
    rst = 1'b0;
    araddr = '0; arvalid = 0; arburst = 0; arlen = 0; arsize = 0; rready = 0;
    awaddr = '0; awvalid = 0; awburst = 0; awlen = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;

    cur = "reset";
    repeat (2) @(negedge clk);
    chk("rvalid", 0, rvalid, 1'b0);
    chk("rlast", 0, rlast, 1'b0);
    chk("bvalid", 0, bvalid, 1'b0);
    chk("rdata", 0, rdata, 64'd0);
    chk("rresp", 0, rresp, 2'b00);
    chk("bresp", 0, bresp, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    chk("arready", 0, arready, 1'b1);
    chk("awready", 0, awready, 1'b1);
    chk("wready", 0, wready, 1'b0);

    cur = "preload";
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      wr(BASE + 32'(blk * 128), 2'd1, 8'd15, w);
    end

    cur = "single";
    wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
    wr(BASE + 32'h10, 2'd1, 8'd0, w);
    rd(BASE + 32'h10, 2'd1, 8'd0, 3'd3, -1, 0, 1'b0, w);
    chk("ar_wait", 0, w, 0);
    chk("value", 0, got[0], 64'h1122334455667788);

    cur = "incr";
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
    wr(BASE, 2'd1, 8'd3, w);
    rd(BASE, 2'd1, 8'd3, 3'd3, 1, 2, 1'b0, w);
    for (int i = 0; i < 4; i++) chk("value", i, got[i], 64'(i + 1));

    cur = "wrap";
    wbuf[0] = {16{4'hA}}; wbuf[1] = {16{4'hB}}; wbuf[2] = {16{4'hC}}; wbuf[3] = {16{4'hD}};
    wr(BASE, 2'd1, 8'd3, w);
    rd(BASE + 32'h10, 2'd2, 8'd3, 3'd3, -1, 0, 1'b0, w);
    chk("beat0", 0, got[0], {16{4'hC}});
    chk("beat1", 1, got[1], {16{4'hD}});
    chk("beat2", 2, got[2], {16{4'hA}});
    chk("beat3", 3, got[3], {16{4'hB}});

    cur = "strobe";
    wbuf[0] = '1; sbuf[0] = 8'hFF;
    wr(BASE + 32'h40, 2'd1, 8'd0, w);
    wbuf[0] = '0; sbuf[0] = 8'h0F;
    wr(BASE + 32'h40, 2'd1, 8'd0, w);
    rd(BASE + 32'h40, 2'd1, 8'd0, 3'd3, -1, 0, 1'b0, w);
    chk("value", 0, got[0], 64'hFFFFFFFF00000000);

    cur = "arb";
    awaddr = BASE + 32'h48; awburst = 2'd1; awlen = 8'd0; awvalid = 1'b1;
    araddr = BASE + 32'h40; arburst = 2'd1; arlen = 8'd1; arsize = 3'd3; arvalid = 1'b1;
    #1;
    chk("awready_low", 0, awready, 1'b0);
    chk("arready_high", 0, arready, 1'b1);
    rd(BASE + 32'h40, 2'd1, 8'd1, 3'd3, -1, 0, 1'b0, w);
    wbuf[0] = 64'h5555_6666_7777_8888; sbuf[0] = 8'hFF;
    wr(BASE + 32'h48, 2'd1, 8'd0, w);
    chk("aw_wait", 0, w, 0);
    rd(BASE + 32'h48, 2'd0, 8'd0, 3'd3, -1, 0, 1'b0, w);
    chk("value", 0, got[0], 64'h5555_6666_7777_8888);

    cur = "oor";
    rd(BASE + 32'(8 * DEPTH), 2'd1, 8'd0, 3'd3, -1, 0, 1'b0, w);
`ifdef AXI_SRAM_RESP_ERR_EN
    chk("value", 0, got[0], 64'd0);
`else
    chk("value", 0, got[0], model[0]);
`endif

    cur = "rst_rd";
    araddr = BASE; arburst = 2'd1; arlen = 8'd7; arsize = 3'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rvalid", 0, rvalid, 1'b0);
    chk("rlast", 0, rlast, 1'b0);
    chk("rdata", 0, rdata, 64'd0);
    @(negedge clk);
    rst = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("arready", 0, arready, 1'b1);

    cur = "rst_wr";
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    wr(BASE + 32'h100, 2'd1, 8'd3, w);
    awaddr = BASE + 32'h100; awburst = 2'd1; awlen = 8'd3; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      model_write(BASE + 32'h100 + 32'(8 * i), wdata, wstrb);
      @(negedge clk);
    end
    wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("bvalid", 0, bvalid, 1'b0);
    chk("wready", 0, wready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(BASE + 32'h100, 2'd1, 8'd3, 3'd3, -1, 0, 1'b0, w);

    cur = "random";
    for (int n = 0; n < 40; n++) begin
      logic [1:0] b;
      logic [7:0] l;
      b = 2'($urandom_range(0, 2));
      l = lens[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
        wr(BASE + 32'(8 * $urandom_range(0, DEPTH - 17)), b, l, w);
      end else begin
        rd(BASE + 32'($urandom_range(0, 8 * DEPTH - 256)), b, l, 3'($urandom_range(0, 3)), -1, 0, 1'b1, w);
        chk("ar_wait", 0, w, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
